// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and mode constants for the VGA raster timing generator.
//   - phase_e      : per-axis raster phase (ACTIVE, FRONT, SYNC, BACK)
//   - VGA640_*     : 640x480@60 timing (default mode, 25.175 MHz pixel clock)
//   - SVGA800_*    : 800x600@60 timing (40 MHz pixel clock)
//   - axis_total() : total length of one axis in pixels/lines
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // 640x480@60
  localparam int VGA640_HD = 640;
  localparam int VGA640_HF = 16;
  localparam int VGA640_HS = 96;
  localparam int VGA640_HB = 48;
  localparam int VGA640_VD = 480;
  localparam int VGA640_VF = 10;
  localparam int VGA640_VS = 2;
  localparam int VGA640_VB = 33;

  // 800x600@60
  localparam int SVGA800_HD = 800;
  localparam int SVGA800_HF = 40;
  localparam int SVGA800_HS = 128;
  localparam int SVGA800_HB = 88;
  localparam int SVGA800_VD = 600;
  localparam int SVGA800_VF = 1;
  localparam int SVGA800_VS = 4;
  localparam int SVGA800_VB = 23;

  function automatic int axis_total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer
//   One raster axis: a position counter 0..T-1 (T = D+F+S+B) plus a 4-phase
//   FSM ACTIVE->FRONT->SYNC->BACK->ACTIVE that tracks which region the counter
//   is in. Both advance only on `step`.
//   Ports:
//     clkP, rstN  : clock, async active-low reset (count=T-1, phase=BACK so the
//                   first step lands on position 0 / ACTIVE)
//     step        : advance one position
//     count/phase : current registered position and phase
//     wrap        : count is at T-1 (next step wraps to 0)
//     count_nxt/phase_nxt : values the registers take on this edge; the top
//                   level registers its outputs from these so they change on
//                   the same edge as the counter.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int D = 640,
  parameter int F = 16,
  parameter int S = 96,
  parameter int B = 48,
  parameter int W = 10
) (
  input  logic         clkP,
  input  logic         rstN,
  input  logic         step,
  output logic [W-1:0] count,
  output logic [1:0]   phase,
  output logic         wrap,
  output logic [W-1:0] count_nxt,
  output logic [1:0]   phase_nxt
);

  localparam int T = axis_total(D, F, S, B);

  // Last position of each phase; the FSM leaves the phase on the step taken there.
  localparam logic [W-1:0] END_ACT = W'(D - 1);
  localparam logic [W-1:0] END_FP  = W'(D + F - 1);
  localparam logic [W-1:0] END_SY  = W'(D + F + S - 1);
  localparam logic [W-1:0] END_BP  = W'(T - 1);

  logic [W-1:0] count_q, count_d;
  phase_e       phase_q, phase_d;

  assign wrap = (count_q == END_BP);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      case (phase_q)
        PH_ACTIVE: if (count_q == END_ACT) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == END_FP)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == END_SY)  phase_d = PH_BACK;
        PH_BACK:   if (wrap)               phase_d = PH_ACTIVE;
        default:                           phase_d = PH_BACK;
      endcase
    end
  end

  always_ff @(posedge clkP or negedge rstN) begin
    if (!rstN) begin
      count_q <= END_BP;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count     = count_q;
  assign phase     = phase_q;
  assign count_nxt = count_d;
  assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator with pixel-clock prescaler.
//   Ports:
//     clkP       : system clock, rising edge
//     rstN       : async active-low reset
//     en         : run enable; low freezes prescaler, counters and outputs
//     pixelTick  : high for the clkP cycle after each pixel tick edge
//     hsync/vsync: sync outputs, active level H_POL / V_POL
//     de         : inside the HD x VD active area
//     pixelX/Y   : current raster position
//     lineStart  : position is at pixelX==0
//     frameStart : position is at (0,0)
//   All outputs are registered from the axis timers' next-state values, so
//   they all change on the edge that registers a tick, with no skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int HD      = VGA640_HD,
  parameter int HF      = VGA640_HF,
  parameter int HS      = VGA640_HS,
  parameter int HB      = VGA640_HB,
  parameter int VD      = VGA640_VD,
  parameter int VF      = VGA640_VF,
  parameter int VS      = VGA640_VS,
  parameter int VB      = VGA640_VB,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int CLK_DIV = 1,
  localparam int HT = HD + HF + HS + HB,
  localparam int VT = VD + VF + VS + VB,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic          clkP,
  input  logic          rstN,
  input  logic          en,
  output logic          pixelTick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] pixelX,
  output logic [VW-1:0] pixelY,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int           DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic         HS_ACT   = (H_POL != 0);
  localparam logic         VS_ACT   = (V_POL != 0);

  // ---------------------------------------------------------------- prescaler
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  assign tick = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clkP or negedge rstN) begin
    if (!rstN) div_q <= '0;
    else       div_q <= div_d;
  end

  // -------------------------------------------------------------- axis timers
  logic [HW-1:0] h_cnt, h_cnt_nxt;
  logic [VW-1:0] v_cnt, v_cnt_nxt;
  logic [1:0]    h_ph, h_ph_nxt, v_ph, v_ph_nxt;
  logic          h_wrap, v_wrap;

  vga_axis_timer #(.D(HD), .F(HF), .S(HS), .B(HB), .W(HW)) u_h (
    .clkP      (clkP),
    .rstN      (rstN),
    .step      (tick),
    .count     (h_cnt),
    .phase     (h_ph),
    .wrap      (h_wrap),
    .count_nxt (h_cnt_nxt),
    .phase_nxt (h_ph_nxt)
  );

  // The line counter steps only on the tick that wraps the pixel counter, so a
  // joint wrap at (HT-1,VT-1) goes straight to (0,0).
  vga_axis_timer #(.D(VD), .F(VF), .S(VS), .B(VB), .W(VW)) u_v (
    .clkP      (clkP),
    .rstN      (rstN),
    .step      (tick & h_wrap),
    .count     (v_cnt),
    .phase     (v_ph),
    .wrap      (v_wrap),
    .count_nxt (v_cnt_nxt),
    .phase_nxt (v_ph_nxt)
  );

  // --------------------------------------------------------- output registers
  logic          pixel_tick_q, pixel_tick_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [HW-1:0] pixel_x_q, pixel_x_d;
  logic [VW-1:0] pixel_y_q, pixel_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    pixel_tick_d  = tick;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (tick) begin
      pixel_x_d     = h_cnt_nxt;
      pixel_y_d     = v_cnt_nxt;
      hsync_d       = (h_ph_nxt == PH_SYNC) ? HS_ACT : ~HS_ACT;
      vsync_d       = (v_ph_nxt == PH_SYNC) ? VS_ACT : ~VS_ACT;
      de_d          = (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
      line_start_d  = (h_cnt_nxt == '0);
      frame_start_d = (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clkP or negedge rstN) begin
    if (!rstN) begin
      pixel_tick_q  <= 1'b0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pixel_tick_q  <= pixel_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixelTick  = pixel_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign pixelX     = pixel_x_q;
  assign pixelY     = pixel_y_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

  // Counter state is fully reflected in the registered outputs; the current
  // phases and the line wrap are only needed inside the timers.
  logic unused_ok;
  assign unused_ok = ^{h_cnt, v_cnt, h_ph, v_ph, v_wrap};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances share one clock:
//   A: tiny mode 4/1/2/1 x 2/1/1/1, H_POL=1, CLK_DIV=1 (HT=8, VT=5)
//   B: same tiny mode, CLK_DIV=3
//   C: default 640x480 mode, CLK_DIV=1 (one full line only)
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_en, a_tick, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [2:0] a_x, a_y;
  logic b_rst_n, b_en, b_tick, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [2:0] b_x, b_y;
  logic c_rst_n, c_en, c_tick, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.HD(4), .HF(1), .HS(2), .HB(1), .VD(2), .VF(1), .VS(1), .VB(1),
                   .H_POL(1), .V_POL(0), .CLK_DIV(1)) dut_a (
    .clkP(clk), .rstN(a_rst_n), .en(a_en), .pixelTick(a_tick), .hsync(a_hs),
    .vsync(a_vs), .de(a_de), .pixelX(a_x), .pixelY(a_y), .lineStart(a_ls),
    .frameStart(a_fs));

  vga_timing_gen #(.HD(4), .HF(1), .HS(2), .HB(1), .VD(2), .VF(1), .VS(1), .VB(1),
                   .H_POL(1), .V_POL(0), .CLK_DIV(3)) dut_b (
    .clkP(clk), .rstN(b_rst_n), .en(b_en), .pixelTick(b_tick), .hsync(b_hs),
    .vsync(b_vs), .de(b_de), .pixelX(b_x), .pixelY(b_y), .lineStart(b_ls),
    .frameStart(b_fs));

  vga_timing_gen dut_c (
    .clkP(clk), .rstN(c_rst_n), .en(c_en), .pixelTick(c_tick), .hsync(c_hs),
    .vsync(c_vs), .de(c_de), .pixelX(c_x), .pixelY(c_y), .lineStart(c_ls),
    .frameStart(c_fs));

  // A's outputs packed as {x,y,de,hs,vs,ls,fs,tick}
  logic [11:0] a_obs;
  assign a_obs = {a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_tick};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
    a_en = 1; b_en = 1; c_en = 1;
    #1;
    cyc();
    checks++;
    if (a_obs !== 12'b000_000_0_0_1_0_0_0) begin
      errors++; $display("FAIL reset_a got %b want 000000001000", a_obs);
    end
    checks++;
    if ({c_x, c_y, c_de, c_hs, c_vs, c_ls, c_fs, c_tick} !== {10'd0, 10'd0, 6'b011000}) begin
      errors++; $display("FAIL reset_c got x=%0d y=%0d de%b hs%b vs%b ls%b fs%b tk%b want 0 0 0 1 1 0 0 0",
                         c_x, c_y, c_de, c_hs, c_vs, c_ls, c_fs, c_tick);
    end
    checks++;
    if ({b_x, b_de, b_fs, b_tick} !== 6'd0) begin
      errors++; $display("FAIL reset_b got x=%0d de%b fs%b tk%b want all 0", b_x, b_de, b_fs, b_tick);
    end
  endtask

  task automatic test_first_tick();
    a_rst_n = 1;
    cyc();
    checks++;
    if (a_obs !== 12'b000_000_1_0_1_1_1_1) begin
      errors++; $display("FAIL first_tick_a got %b want 000000101111", a_obs);
    end
  endtask

  // Two full frames of A against a position model, starting at (0,0).
  task automatic test_small_frame();
    logic [7:0] hs_tab;
    logic [11:0] exp;
    int x, y, fs_cnt, vs_cnt, de_cnt, fs_last, fs_gap;
    hs_tab = 8'b0110_0000;  // hsync per pixelX 0..7: 0,0,0,0,0,1,1,0
    x = 0; y = 0; fs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs_last = -1; fs_gap = 0;
    for (int i = 0; i < 80; i++) begin
      exp = {x[2:0], y[2:0], (x < 4 && y < 2), hs_tab[x], (y != 3), (x == 0),
             (x == 0 && y == 0), 1'b1};
      checks++;
      if (a_obs !== exp) begin
        errors++; $display("FAIL frame_a i=%0d got %b want %b", i, a_obs, exp);
      end
      if (a_fs) begin
        if (fs_last >= 0) fs_gap = i - fs_last;
        fs_last = i; fs_cnt++;
      end
      if (!a_vs) vs_cnt++;
      if (a_de) de_cnt++;
      cyc();
      if (x == 7) begin x = 0; y = (y == 4) ? 0 : y + 1; end
      else x++;
    end
    checks++;
    if (fs_cnt != 2 || fs_gap != 40) begin
      errors++; $display("FAIL frame_start_period got cnt=%0d gap=%0d want 2 40", fs_cnt, fs_gap);
    end
    checks++;
    if (vs_cnt != 16) begin
      errors++; $display("FAIL vsync_ticks got %0d want 16", vs_cnt);
    end
    checks++;
    if (de_cnt != 16) begin
      errors++; $display("FAIL de_ticks got %0d want 16", de_cnt);
    end
  endtask

  task automatic test_wrap();
    repeat (39) cyc();
    checks++;
    if (a_obs !== 12'b111_100_0_0_1_0_0_1) begin
      errors++; $display("FAIL wrap_last got %b want 111100001001", a_obs);
    end
    cyc();
    checks++;
    if (a_obs !== 12'b000_000_1_0_1_1_1_1) begin
      errors++; $display("FAIL wrap_next got %b want 000000101111", a_obs);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (a_x == 3'd6 && a_y == 3'd3) found = 1;
      else cyc();
    end
    checks++;
    if (!found || a_obs !== 12'b110_011_0_1_0_0_0_1) begin
      errors++; $display("FAIL mid_frame_pos found=%0d got %b want 110011010001", found, a_obs);
    end
    a_rst_n = 0;
    #1;
    checks++;
    if (a_obs !== 12'b000_000_0_0_1_0_0_0) begin
      errors++; $display("FAIL async_reset got %b want 000000001000", a_obs);
    end
    cyc();
    a_rst_n = 1;
    cyc();
    checks++;
    if (a_obs !== 12'b000_000_1_0_1_1_1_1) begin
      errors++; $display("FAIL reset_restart got %b want 000000101111", a_obs);
    end
  endtask

  task automatic test_clk_div();
    logic [5:0] exp;
    int ex;
    b_rst_n = 1;
    for (int k = 1; k <= 23; k++) begin
      cyc();
      ex = (k >= 3) ? (k / 3 - 1) : 0;
      exp = {ex[2:0], (k >= 3 && ex < 4), (k >= 3 && k < 6), (k % 3 == 0)};
      checks++;
      if ({b_x, b_de, b_fs, b_tick} !== exp) begin
        errors++; $display("FAIL clk_div k=%0d got x=%0d de%b fs%b tk%b want %b",
                           k, b_x, b_de, b_fs, b_tick, exp);
      end
    end
  endtask

  // One full line of the default mode with a 7-cycle enable drop at pixelX=100.
  task automatic test_en_drop_line();
    logic [26:0] obs, exp;
    int hs_cnt, hs_first, de_cnt;
    hs_cnt = 0; hs_first = -1; de_cnt = 0;
    c_rst_n = 1;
    for (int ex = 0; ex < 800; ex++) begin
      cyc();
      obs = {c_x, c_y, c_de, c_hs, c_vs, c_ls, c_fs, c_tick};
      exp = {ex[9:0], 10'd0, (ex < 640), !(ex >= 656 && ex < 752), 1'b1,
             (ex == 0), (ex == 0), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL line_c x=%0d got %h want %h", ex, obs, exp);
      end
      if (!c_hs) begin
        if (hs_first < 0) hs_first = int'(c_x);
        hs_cnt++;
      end
      if (c_de) de_cnt++;
      if (ex == 100) begin
        c_en = 0;
        for (int j = 0; j < 7; j++) begin
          cyc();
          checks++;
          if ({c_x, c_tick, c_de, c_hs} !== {10'd100, 3'b011}) begin
            errors++; $display("FAIL en_hold j=%0d got x=%0d tk%b de%b hs%b want 100 0 1 1",
                               j, c_x, c_tick, c_de, c_hs);
          end
        end
        c_en = 1;
      end
    end
    cyc();
    checks++;
    if ({c_x, c_y, c_de, c_ls, c_fs} !== {10'd0, 10'd1, 3'b110}) begin
      errors++; $display("FAIL line_wrap got x=%0d y=%0d de%b ls%b fs%b want 0 1 1 1 0",
                         c_x, c_y, c_de, c_ls, c_fs);
    end
    checks++;
    if (hs_cnt != 96 || hs_first != 656) begin
      errors++; $display("FAIL hsync_pulse got len=%0d start=%0d want 96 656", hs_cnt, hs_first);
    end
    checks++;
    if (de_cnt != 640) begin
      errors++; $display("FAIL de_line got %0d want 640", de_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_small_frame();
    test_wrap();
    test_reset_mid_frame();
    test_clk_div();
    test_en_drop_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
